// File: rtl/sobel_grad_stream_if.sv
// Pixel stream bus for sobel_grad_stream: input pixels, per-frame config, edge output.
interface sobel_grad_stream_if #(
    parameter int DW = 8
);
    logic [DW-1:0] din;
    logic          din_vld;
    logic          din_sop;
    logic          din_eop;
    logic          mode;
    logic [DW+1:0] thresh;
    logic [DW-1:0] dout;
    logic          dout_vld;
    logic          dout_sop;
    logic          dout_eop;

    modport master (
        output din, din_vld, din_sop, din_eop, mode, thresh,
        input  dout, dout_vld, dout_sop, dout_eop
    );

    modport slave (
        input  din, din_vld, din_sop, din_eop, mode, thresh,
        output dout, dout_vld, dout_sop, dout_eop
    );
endinterface

// File: rtl/sobel_grad_stream.sv
// Streaming 3x3 Sobel edge detector: two line buffers, window register,
// gradient stage, magnitude/threshold stage; fixed 3-cycle latency, no backpressure.
module sobel_grad_stream #(
    parameter int DW    = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic               clk,
    input  logic               rst_n,
    sobel_grad_stream_if.slave s
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int GW = DW + 3;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [GW-1:0] PIX_MAX  = GW'((1 << DW) - 1);

    logic [CW-1:0] col_q, col_d, pix_col;
    logic [RW-1:0] row_q, row_d, pix_row;
    logic          mode_q, mode_d, pix_mode;
    logic [DW+1:0] thr_q, thr_d, pix_thr;

    // A valid sop pixel takes position (0,0) and its own mode/thresh immediately.
    always_comb begin
        pix_col  = s.din_sop ? '0 : col_q;
        pix_row  = s.din_sop ? '0 : row_q;
        pix_mode = s.din_sop ? s.mode : mode_q;
        pix_thr  = s.din_sop ? s.thresh : thr_q;
        col_d    = col_q;
        row_d    = row_q;
        mode_d   = mode_q;
        thr_d    = thr_q;
        if (s.din_vld) begin
            mode_d = pix_mode;
            thr_d  = pix_thr;
            if (pix_col == COL_LAST) begin
                col_d = '0;
                row_d = (pix_row == ROW_LAST) ? pix_row : pix_row + 1'b1;
            end else begin
                col_d = pix_col + 1'b1;
                row_d = pix_row;
            end
        end
    end

    logic [DW-1:0] lb1_q [IMG_W];
    logic [DW-1:0] lb2_q [IMG_W];
    logic [DW-1:0] lb1_rd, lb2_rd;

    assign lb1_rd = lb1_q[pix_col];
    assign lb2_rd = lb2_q[pix_col];

    always_ff @(posedge clk) begin
        if (s.din_vld) begin
            lb1_q[pix_col] <= s.din;
            lb2_q[pix_col] <= lb1_rd;
        end
    end

    // Window rows: 0 = row-2, 1 = row-1, 2 = current row; column 2 is newest.
    logic [DW-1:0] win_q [3][3];

    always_ff @(posedge clk) begin
        if (s.din_vld) begin
            for (int unsigned r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= lb2_rd;
            win_q[1][2] <= lb1_rd;
            win_q[2][2] <= s.din;
        end
    end

    logic          s1_vld_q, s1_sop_q, s1_eop_q, s1_zero_q, s1_mode_q;
    logic [DW+1:0] s1_thr_q;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            col_q     <= '0;
            row_q     <= '0;
            mode_q    <= 1'b0;
            thr_q     <= '0;
            s1_vld_q  <= 1'b0;
            s1_sop_q  <= 1'b0;
            s1_eop_q  <= 1'b0;
            s1_zero_q <= 1'b0;
            s1_mode_q <= 1'b0;
            s1_thr_q  <= '0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            mode_q   <= mode_d;
            thr_q    <= thr_d;
            s1_vld_q <= s.din_vld;
            s1_sop_q <= s.din_vld & s.din_sop;
            s1_eop_q <= s.din_vld & s.din_eop;
            if (s.din_vld) begin
                s1_zero_q <= (32'(pix_row) < 2) || (32'(pix_col) < 2);
                s1_mode_q <= pix_mode;
                s1_thr_q  <= pix_thr;
            end
        end
    end

    // Gradients kept as two's complement in GW bits; range +-4*(2^DW-1) always fits.
    logic [GW-1:0] gx_pos, gx_neg, gy_pos, gy_neg, gx_d, gy_d;

    always_comb begin
        gx_pos = GW'(win_q[0][2]) + (GW'(win_q[1][2]) << 1) + GW'(win_q[2][2]);
        gx_neg = GW'(win_q[0][0]) + (GW'(win_q[1][0]) << 1) + GW'(win_q[2][0]);
        gy_pos = GW'(win_q[2][0]) + (GW'(win_q[2][1]) << 1) + GW'(win_q[2][2]);
        gy_neg = GW'(win_q[0][0]) + (GW'(win_q[0][1]) << 1) + GW'(win_q[0][2]);
        gx_d   = gx_pos - gx_neg;
        gy_d   = gy_pos - gy_neg;
    end

    logic [GW-1:0] gx_q, gy_q;
    logic          s2_vld_q, s2_sop_q, s2_eop_q, s2_zero_q, s2_mode_q;
    logic [DW+1:0] s2_thr_q;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            s2_vld_q  <= 1'b0;
            s2_sop_q  <= 1'b0;
            s2_eop_q  <= 1'b0;
            s2_zero_q <= 1'b0;
            s2_mode_q <= 1'b0;
            s2_thr_q  <= '0;
            gx_q      <= '0;
            gy_q      <= '0;
        end else begin
            s2_vld_q <= s1_vld_q;
            s2_sop_q <= s1_sop_q;
            s2_eop_q <= s1_eop_q;
            if (s1_vld_q) begin
                gx_q      <= gx_d;
                gy_q      <= gy_d;
                s2_zero_q <= s1_zero_q;
                s2_mode_q <= s1_mode_q;
                s2_thr_q  <= s1_thr_q;
            end
        end
    end

    logic [GW-1:0] abs_x, abs_y, mag;
    logic [DW-1:0] res_d;

    always_comb begin
        abs_x = gx_q[GW-1] ? (~gx_q + 1'b1) : gx_q;
        abs_y = gy_q[GW-1] ? (~gy_q + 1'b1) : gy_q;
        mag   = abs_x + abs_y;
        res_d = '0;
        if (!s2_zero_q) begin
            if (s2_mode_q) begin
                res_d = (mag > PIX_MAX) ? '1 : mag[DW-1:0];
            end else begin
                res_d = (mag >= {1'b0, s2_thr_q}) ? '1 : '0;
            end
        end
    end

    logic [DW-1:0] dout_q;
    logic          dout_vld_q, dout_sop_q, dout_eop_q;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            dout_sop_q <= 1'b0;
            dout_eop_q <= 1'b0;
        end else begin
            dout_vld_q <= s2_vld_q;
            dout_sop_q <= s2_sop_q;
            dout_eop_q <= s2_eop_q;
            if (s2_vld_q) begin
                dout_q <= res_d;
            end
        end
    end

    assign s.dout     = dout_q;
    assign s.dout_vld = dout_vld_q;
    assign s.dout_sop = dout_sop_q;
    assign s.dout_eop = dout_eop_q;
endmodule

// File: tb/tb_sobel_grad_stream.sv
// Randomized bench for sobel_grad_stream against a frame-history Sobel reference model.
module tb_sobel_grad_stream;
    localparam int DW   = 8;
    localparam int W    = 8;
    localparam int H    = 8;
    localparam int NPIX = W * H;

    logic clk = 1'b0;
    logic rst_n;

    sobel_grad_stream_if #(.DW(DW)) bus ();

    sobel_grad_stream #(
        .DW(DW),
        .IMG_W(W),
        .IMG_H(H)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .s(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int val;
        bit sop;
        bit eop;
    } exp_t;

    exp_t exp_q[$];
    int   hist[$];
    int   k_pix;
    int   m_mode;
    int   m_thr;
    int   cyc;
    int   n_checks;
    int   n_fail;
    int   img[NPIX];

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Pixel k of the current frame; window element (i,j) lies (2-i) lines and (2-j) pixels back.
    function automatic int ref_val(input int k);
        int r, c, gx, gy, sm;
        int p[3][3];
        r = k / W;
        if (r > H - 1) r = H - 1;
        c = k % W;
        if (r < 2 || c < 2) return 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                p[i][j] = hist[k - (2 - i) * W - (2 - j)];
        gx = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
        gy = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
        sm = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (m_mode != 0) return (sm > 255) ? 255 : sm;
        return (sm >= m_thr) ? 255 : 0;
    endfunction

    task automatic model_reset();
        hist.delete();
        k_pix  = 0;
        m_mode = 0;
        m_thr  = 0;
    endtask

    task automatic check_out();
        exp_t e;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            chk("dout_vld", int'(bus.dout_vld), 1);
            chk("dout", int'(bus.dout), e.val);
            chk("dout_sop", int'(bus.dout_sop), int'(e.sop));
            chk("dout_eop", int'(bus.dout_eop), int'(e.eop));
        end else begin
            chk("idle_vld", int'(bus.dout_vld), 0);
            chk("idle_sop", int'(bus.dout_sop), 0);
            chk("idle_eop", int'(bus.dout_eop), 0);
        end
    endtask

    task automatic drive(input bit vld, input int d, input bit sop, input bit eop,
                         input bit md, input int th);
        exp_t e;
        @(negedge clk);
        cyc++;
        check_out();
        bus.din_vld = vld;
        bus.din     = d[DW-1:0];
        bus.din_sop = sop;
        bus.din_eop = eop;
        bus.mode    = md;
        bus.thresh  = th[DW+1:0];
        if (vld) begin
            if (sop) begin
                hist.delete();
                k_pix  = 0;
                m_mode = int'(md);
                m_thr  = th;
            end
            hist.push_back(d);
            e.due = cyc + 3;
            e.val = ref_val(k_pix);
            e.sop = sop;
            e.eop = eop;
            exp_q.push_back(e);
            k_pix++;
        end
    endtask

    // Idle cycles carry junk on every qualified field to prove din_vld gating.
    task automatic idle();
        drive(1'b0, int'($urandom_range(255)), 1'($urandom_range(1)), 1'($urandom_range(1)),
              1'($urandom_range(1)), int'($urandom_range(1023)));
    endtask

    task automatic send_px(input int d, input bit sop, input bit eop, input bit md,
                           input int th, input int gap_pct);
        for (int g = 0; g < 4; g++) begin
            if (int'($urandom_range(99)) >= gap_pct) break;
            idle();
        end
        if (sop) drive(1'b1, d, 1'b1, eop, md, th);
        else     drive(1'b1, d, 1'b0, eop, 1'($urandom_range(1)), int'($urandom_range(1023)));
    endtask

    task automatic send_frame(input bit md, input int th, input int gap_pct,
                              input int npx, input bit with_eop);
        for (int i = 0; i < npx; i++)
            send_px(img[i % NPIX], i == 0, with_eop && (i == npx - 1), md, th, gap_pct);
    endtask

    task automatic fill(input int kind);
        for (int i = 0; i < NPIX; i++) begin
            case (kind)
                0:       img[i] = 'h40;
                1:       img[i] = ((i % W) >= 4) ? 'hFF : 'h00;
                2:       img[i] = ((i / W) * 24 + (i % W) * 9) % 256;
                default: img[i] = int'($urandom_range(255));
            endcase
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        cyc++;
        check_out();
        rst_n       = 1'b1;
        bus.din_vld = 1'b0;
        bus.din_sop = 1'b0;
        bus.din_eop = 1'b0;
        while (exp_q.size() > 0 && exp_q[exp_q.size() - 1].due > cyc)
            void'(exp_q.pop_back());
        model_reset();
        @(negedge clk);
        cyc++;
        chk("rst_dout", int'(bus.dout), 0);
        chk("rst_vld", int'(bus.dout_vld), 0);
        chk("rst_sop", int'(bus.dout_sop), 0);
        chk("rst_eop", int'(bus.dout_eop), 0);
        rst_n = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        cyc         = 0;
        rst_n       = 1'b1;
        bus.din     = '0;
        bus.din_vld = 1'b0;
        bus.din_sop = 1'b0;
        bus.din_eop = 1'b0;
        bus.mode    = 1'b0;
        bus.thresh  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("init_dout", int'(bus.dout), 0);
        chk("init_vld", int'(bus.dout_vld), 0);
        chk("init_sop", int'(bus.dout_sop), 0);
        chk("init_eop", int'(bus.dout_eop), 0);
        rst_n = 1'b0;

        // Pixels ahead of any sop run with mode 0 / thresh 0 from the reset state.
        fill(3);
        for (int i = 0; i < 24; i++)
            drive(1'b1, img[i], 1'b0, 1'b0, 1'b1, int'($urandom_range(1023)));

        fill(0);
        send_frame(1'b1, 0, 0, NPIX, 1'b1);
        fill(1);
        send_frame(1'b1, 0, 0, NPIX, 1'b1);
        send_frame(1'b0, 500, 0, NPIX, 1'b1);
        send_frame(1'b0, 1021, 0, NPIX, 1'b1);
        fill(2);
        send_frame(1'b1, 0, 0, NPIX, 1'b1);
        send_frame(1'b1, 0, 50, NPIX, 1'b1);

        for (int f = 0; f < 4; f++) begin
            fill(3);
            send_frame(1'($urandom_range(1)), int'($urandom_range(1023)), 30, NPIX, 1'b1);
        end

        fill(3);
        send_frame(1'b1, 0, 20, 20, 1'b0);
        send_frame(1'b0, 300, 20, NPIX, 1'b1);

        send_frame(1'b1, 0, 10, 80, 1'b1);

        send_frame(1'b1, 0, 0, 36, 1'b0);
        do_reset();
        repeat (4) idle();
        fill(3);
        send_frame(1'b1, 0, 25, NPIX, 1'b1);

        repeat (6) idle();
        chk("exp_q_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sobel_grad_stream.md
SOBEL_GRAD_STREAM -- requirements
Module: sobel_grad_stream

Interface
REQ-001 Parameter DW, default 8, pixel data width in bits (4..12).
REQ-002 Parameter IMG_W, default 640, active pixels per line.
REQ-003 Parameter IMG_H, default 480, active lines per frame.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset; one clock; reset is synchronous and active-high.
REQ-006 din  input  DW  grayscale pixel, unsigned.
REQ-007 din_vld  input  1  din valid this cycle; gaps allowed.
REQ-008 din_sop  input  1  first pixel of frame; qualified by din_vld.
REQ-009 din_eop  input  1  last pixel of frame; qualified by din_vld.
REQ-010 mode  input  1  0 = binary edge output, 1 = gradient magnitude output.
REQ-011 thresh  input  DW+2  binary-mode threshold on |Gx|+|Gy|.
REQ-012 dout  output  DW  edge result.
REQ-013 dout_vld, dout_sop, dout_eop  output  1 each  stream qualifiers aligned to dout.

Function
REQ-014 Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) SHALL advance only on din_vld; col wraps IMG_W-1 -> 0 and increments row.
REQ-015 din_vld with din_sop SHALL force col=0,row=0 for that pixel, regardless of counter state (mid-frame sop restarts frame).
REQ-016 row SHALL saturate at IMG_H-1 if more pixels than a frame arrive before the next sop; no wrap.
REQ-017 Two line buffers of IMG_W x DW SHALL hold rows row-1 and row-2, indexed by col; written/shifted only on din_vld; contents not cleared by sop or reset.
REQ-018 3x3 window SHALL be formed from din and the two line-buffer outputs, shifted one column per din_vld; newest sample = bottom-right.
REQ-019 Gx = (p02+2p12+p22)-(p00+2p10+p20), Gy = (p20+2p21+p22)-(p00+2p01+p02), computed signed, DW+3 bits, no overflow.
REQ-020 S = |Gx|+|Gy|, unsigned, DW+3 bits.
REQ-021 mode=1: dout = S saturated to 2^DW-1.
REQ-022 mode=0: dout = all ones when S >= thresh, else 0.
REQ-023 Each output pixel corresponds one-to-one to an input pixel at (row,col); value is the window centred at (row-1,col-1).
REQ-024 dout SHALL be 0 when row<2 or col<2 (incomplete window), both modes; dout_vld still asserted.
REQ-025 Latency: dout_vld SHALL assert exactly 3 clk after the din_vld cycle, independent of input gaps; stages: window register, Gx/Gy, S/threshold.
REQ-026 dout_sop/dout_eop SHALL be din_sop/din_eop delayed with the same 3-cycle valid tag; low whenever dout_vld low.
REQ-027 mode and thresh SHALL be sampled on din_vld&din_sop and held for the frame; mid-frame changes take effect at next sop.
REQ-028 Before first sop after reset, input pixels SHALL be processed with mode=0, thresh=0 sampled values and row/col from reset state.
REQ-029 Block has no backpressure; one output per input, throughput one pixel/clk.

Reset
REQ-030 rst_n high SHALL clear row, col, pipeline valid tags, dout, dout_vld, dout_sop, dout_eop, sampled mode/thresh to 0 on the next clk edge.
REQ-031 Reset mid-frame SHALL drop in-flight pixels: no dout_vld in the 3 cycles after reset deasserts unless new din_vld arrives.

Verification
REQ-032 DW=8, IMG_W=8, IMG_H=8, flat frame of 0x40, mode=1 -> 64 outputs, all dout=0x00, dout_sop on first, dout_eop on last, each 3 clk after input.
REQ-033 Vertical step (cols 0-3 = 0x00, cols 4-7 = 0xFF), mode=1 -> rows>=2 at cols 4,5 output 0xFF (S=1020 saturated), others 0.
REQ-034 Same step, mode=0, thresh=500 -> cols 4,5 rows>=2 dout=0xFF, all else 0x00; thresh=1021 -> all 0x00.
REQ-035 Random din_vld gaps (50% duty) on 8x8 ramp -> output values identical to gap-free run; every dout_vld exactly 3 clk after its din_vld.
REQ-036 din_sop reasserted at pixel 20 of a frame -> counters restart; outputs for first two rows/cols of new frame are 0.
REQ-037 rst_n pulsed during row 4 -> all outputs 0 next cycle; no dout_vld until fresh din_vld; next frame matches golden model.
